dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 255, the max BUSY cycles waited for mem_ack before abort (legal 1..1023).
REQ-002 SHALL provide: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL provide: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide core side: req_valid in 1 (load/store present); req_we in 1 (1=store); req_funct3 in 3 (RV32I width code); req_addr in 32 (byte address); req_wdata in 32 (store data).
REQ-005 SHALL provide core outputs: stall out 1 (hold PC); rsp_valid out 1 (one-cycle completion); rsp_rdata out 32 (extended load data); err out 1 (one-cycle fault).
REQ-006 SHALL provide memory side: mem_req out 1; mem_we out 1; mem_addr out 30 (word address); mem_be out 4; mem_wdata out 32; mem_ack in 1; mem_rdata in 32.

Function
REQ-007 SHALL implement FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-008 SHALL classify a request as faulty when funct3 in {3,6,7}, or halfword (1,5) with addr[0]=1, or word (2) with addr[1:0]!=0; stores with funct3>2 are faulty.
REQ-009 SHALL, in IDLE with req_valid and no fault, capture we/funct3/addr[1:0]/word address/lane data and move to BUSY next edge.
REQ-010 SHALL, in IDLE with req_valid and fault, move to DONE with err pending; no mem_req is ever issued for it.
REQ-011 SHALL drive stall combinationally = (IDLE and req_valid) or BUSY; stall SHALL be 0 in DONE.
REQ-012 SHALL drive mem_req=1 for every BUSY cycle, address/be/we/wdata stable from entry until ack.
REQ-013 SHALL, in BUSY, go to DONE on the edge where mem_ack=1; mem_ack while not BUSY is ignored.
REQ-014 SHALL count BUSY cycles; when count reaches TIMEOUT with no ack, go to DONE with err pending and rsp_rdata=0.
REQ-015 SHALL, in DONE, assert rsp_valid=1 for exactly one cycle, err=1 only if faulted/timed out, then return to IDLE regardless of req_valid.
REQ-016 SHALL generate mem_be: byte -> 1 lane selected by addr[1:0]; half -> 4'b0011 or 4'b1100 by addr[1]; word -> 4'b1111; loads use same mask.
REQ-017 SHALL replicate store data: SB -> {4{wdata[7:0]}}, SH -> {2{wdata[15:0]}}, SW -> wdata.
REQ-018 SHALL register load result on ack: select lane by captured addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass; stores load 0.
REQ-019 SHALL hold rsp_rdata until the next DONE entry.
REQ-020 SHALL complete a zero-wait access (ack in first BUSY cycle) in 3 cycles: IDLE, BUSY, DONE.

Reset
REQ-021 SHALL, on rst_n=0, immediately force IDLE, mem_req=0, rsp_valid=0, err=0, rsp_rdata=0, mem_be=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0.
REQ-022 SHALL abandon any in-flight transaction on reset with no response generated; an ack after reset is ignored.

Verification
REQ-023 LW addr 0x100, mem_rdata 0xDEADBEEF, ack first BUSY cycle -> mem_addr 0x40, be 4'b1111, rsp_rdata 0xDEADBEEF, rsp_valid in cycle 3, stall high cycles 1-2.
REQ-024 LB addr 0x103, mem_rdata 0x80123456 -> be 4'b1000, rsp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-025 SH addr 0x202, wdata 0x0000ABCD, ack after 5 wait cycles -> mem_wdata 0xABCDABCD, be 4'b1100, we=1, mem_req high 6 cycles, rsp_valid once.
REQ-026 LW addr 0x101 -> no mem_req, err=1 and rsp_valid=1 in cycle 2, stall only cycle 1.
REQ-027 TIMEOUT=4, LW, no ack -> mem_req high 4 cycles, then err=1, rsp_rdata 0.
REQ-028 rst_n low mid-BUSY, ack next cycle -> mem_req drops at once, no rsp_valid, state IDLE.

Source files
------------

// File: rtl/dmem_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_ctrl
// Data-memory access controller between an RV32I core load/store port and a
// word-addressed memory with a request/acknowledge handshake.
//
// A core request is checked for misalignment and illegal width codes. A legal
// request is latched into the memory-side registers (word address, byte
// enables, lane-replicated store data) and held there while mem_req is high,
// until mem_ack arrives or the wait budget TIMEOUT runs out. An illegal
// request never reaches memory and is answered with err. Every request ends
// with exactly one DONE cycle in which rsp_valid (and err if it faulted) is
// high.
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   req_valid        : core presents a load/store this cycle
//   req_we           : 1 = store, 0 = load
//   req_funct3       : RV32I width code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr         : byte address
//   req_wdata        : store data (low bits hold the value)
//   stall            : hold the core PC (combinational)
//   rsp_valid        : one-cycle completion strobe
//   rsp_rdata        : extended load data, held until the next completion
//   err              : one-cycle fault strobe (misaligned/illegal/timeout)
//   mem_req          : memory request, high for every BUSY cycle
//   mem_we           : memory write enable
//   mem_addr         : word address
//   mem_be           : byte-lane enables
//   mem_wdata        : lane-replicated store data
//   mem_ack          : memory acknowledge (only honoured in BUSY)
//   mem_rdata        : memory read data
// ----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 32'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last BUSY cycle index allowed before the wait is abandoned.
  localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT - 32'd1);

  state_t      state_r;
  logic [9:0]  cnt_r;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [1:0]  off_r;
  logic        fault_s;

  // Illegal width codes, misaligned halfword/word, and unsigned-store codes.
  function automatic logic is_fault(input logic we, input logic [2:0] f3,
                                    input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (f3)
      3'd0:    bad = 1'b0;
      3'd1:    bad = a[0];
      3'd2:    bad = (a != 2'b00);
      3'd4:    bad = we;
      3'd5:    bad = we | a[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte-lane mask from access size (f3[1:0]) and byte offset.
  function automatic logic [3:0] be_mask(input logic [1:0] size,
                                         input logic [1:0] a);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store value across all lanes so the byte enables pick it up.
  function automatic logic [31:0] store_data(input logic [1:0] size,
                                             input logic [31:0] wd);
    logic [31:0] d;
    d = 32'h0000_0000;
    case (size)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Bring the addressed lane down to bit 0 and sign/zero extend by width code.
  function automatic logic [31:0] load_data(input logic [2:0] f3,
                                            input logic [1:0] a,
                                            input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] d;
    sh = rd >> {a, 3'b000};
    d  = 32'h0000_0000;
    case (f3)
      3'd0:    d = {{24{sh[7]}}, sh[7:0]};
      3'd1:    d = {{16{sh[15]}}, sh[15:0]};
      3'd2:    d = rd;
      3'd4:    d = {24'h00_0000, sh[7:0]};
      3'd5:    d = {16'h0000, sh[15:0]};
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  // Fault classification of the request currently on the core port.
  always_comb begin
    fault_s = is_fault(req_we, req_funct3, req_addr[1:0]);
  end

  // Core stall: hold the PC while a request is being accepted or is in flight.
  always_comb begin
    if (state_r == BUSY) begin
      stall = 1'b1;
    end else if (state_r == IDLE) begin
      stall = req_valid;
    end else begin
      stall = 1'b0;
    end
  end

  // Controller FSM with registered memory-side and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= 10'd0;
      we_r      <= 1'b0;
      funct3_r  <= 3'd0;
      off_r     <= 2'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 30'h0000_0000;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0000_0000;
    end else begin
      // Completion strobes last one cycle unless re-armed below.
      rsp_valid <= 1'b0;
      err       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            if (fault_s) begin
              state_r   <= DONE;
              rsp_valid <= 1'b1;
              err       <= 1'b1;
              rsp_rdata <= 32'h0000_0000;
            end else begin
              state_r   <= BUSY;
              cnt_r     <= 10'd0;
              we_r      <= req_we;
              funct3_r  <= req_funct3;
              off_r     <= req_addr[1:0];
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= req_addr[31:2];
              mem_be    <= be_mask(req_funct3[1:0], req_addr[1:0]);
              mem_wdata <= store_data(req_funct3[1:0], req_wdata);
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          // An ack on the final budgeted cycle still completes normally.
          if (mem_ack) begin
            state_r   <= DONE;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= we_r ? 32'h0000_0000
                              : load_data(funct3_r, off_r, mem_rdata);
          end else if (cnt_r >= TIMEOUT_LAST) begin
            state_r   <= DONE;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            err       <= 1'b1;
            rsp_rdata <= 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + 10'd1;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
